des3_kat_checker: RTL
=====================

// Module: des3_kat_checker
// PURPOSE
//  Built-in known-answer self test for the des3 core; it receives and checks what the core produces.
//  - Steps through an internal vector table and drives the core's input, key and mode ports.
//  - Waits the core latency, captures desOut and compares it to the expected ciphertext.
//  - Decrypts the captured result and checks that it returns the original plaintext.
//  - Sits beside des3 in the top level and reports pass/fail to the host register block.
// PARAMETERS
//  NUM_VEC       4   number of vectors in the table (1..256)
//  CORE_LATENCY  48  clocks from a des3 input change to a valid desOut (>=1)
// PORTS
//  clk         in   1   system clock, rising edge
//  reset_n     in   1   asynchronous active-low reset
//  start       in   1   one-cycle pulse; starts a self test when idle
//  busy        out  1   high while a test is running
//  done        out  1   high from test end until the next accepted start
//  pass        out  1   valid while done=1; 1 = all vectors passed both phases
//  fail_index  out  8   index of the first failing vector (0 if pass)
//  fail_phase  out  1   0 = encrypt mismatch, 1 = round-trip decrypt mismatch
//  desIn       out  64  data to des3
//  key1        out  56  des3 key 1, parity stripped
//  key2        out  56  des3 key 2, parity stripped
//  key3        out  56  des3 key 3, parity stripped
//  decrypt     out  1   des3 mode: 0 = encrypt, 1 = decrypt
//  desOut      in   64  result from des3
// BEHAVIOUR
//  Reset
//  - busy=0, done=0, pass=0, fail_index=0, fail_phase=0, desIn=0, keys=0, decrypt=0.
//  - State returns to IDLE.
//  - reset_n asserted mid-test aborts immediately; no partial result is reported.
//  Vector format: 320-bit word, fields in order {k1, k2, k3, pt, ct}, 64 bits each.
//  - Each key drops bit 0 of every byte (parity): {k[63:57], k[55:49], ..., k[7:1]}.
//  FSM states
//  - IDLE: on start -> LOAD. Clears done, pass, fail_* and sets idx=0, busy=1.
//  - LOAD: takes 1 clk. Registers vector[idx] and drives keys, desIn=pt, decrypt=0. -> ENC.
//  - ENC: holds the drive for CORE_LATENCY clks via the wait counter. -> CHK_E.
//  - CHK_E: samples desOut.
//    - Mismatch with ct -> FAIL, with fail_phase=0.
//    - Match -> stores the result r, sets desIn=r, decrypt=1 -> DEC.
//  - DEC: waits CORE_LATENCY clks. -> CHK_D.
//  - CHK_D: compares desOut with pt.
//    - Mismatch -> FAIL, with fail_phase=1.
//    - Match and idx==NUM_VEC-1 -> PASS.
//    - Otherwise idx++ -> LOAD.
//  - PASS / FAIL: take 1 clk. Set done=1, busy=0, and pass=1 or 0. fail_index=idx on FAIL. -> IDLE.
//  Handshake and timing
//  - start while busy is ignored.
//  - start in the same cycle as done rising is ignored.
//  - start while done=1 restarts the test.
//  - Core inputs are held stable for the whole wait window; the core sees no change mid-latency.
//  - Per-vector latency: 1 + 2*(CORE_LATENCY+1) clks.
//  - Total time from start to done: NUM_VEC * (2*CORE_LATENCY + 3) + 1 clks.
//  - The test stops at the first failure; the remaining vectors are not run.
//  Counters
//  - Wait counter width is clog2(CORE_LATENCY+1); it reloads on every state entry.
//  - idx is 8 bits and never wraps, because NUM_VEC<=256 is checked at elaboration.
// STRUCTURE
//  - Package des3_kat_pkg: state enum, vector field offsets, the key parity-strip function,
//    and the vector table constant.
//  - Vector 0 is k1=k2=k3=64'h0101010101010101, pt=64'h95F8A5E5DD31D900, ct=64'h8000000000000000.
//  - One sub-module, des3_kat_rom: an idx -> 320-bit combinational lookup from the package table.
//  - The FSM, the wait counter and result capture stay in this module.
// TESTING
//  - All-pass run: bench des3 model with latency 48 and vector 0 -> done after
//    4*99+1 clks, pass=1, fail_index=0; desIn sequence 95F8.., then 8000.. with decrypt=1.
//  - Encrypt fault: model flips desOut[0] when vector 2 is encrypted -> pass=0, fail_index=2, fail_phase=0.
//  - Decrypt fault: model returns 0 for decrypt of vector 1 -> pass=0, fail_index=1, fail_phase=1.
//  - start pulsed at cycle 10 of ENC -> ignored; the run still completes in exactly the nominal clks.
//  - reset_n low during the DEC of vector 1 -> all outputs 0 next clk. A later start runs a full test and passes.
//  - Parameter sweep: CORE_LATENCY=1, NUM_VEC=1 -> done exactly 6 clks after start, pass=1.

Source files
------------

// File: rtl/des3_kat_pkg.sv
// Shared types, vector layout and the known-answer table for the des3 self test.
// Each table entry packs {k1, k2, k3, pt, ct}; keys still carry DES parity bits.
package des3_kat_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ENC   = 3'd2,
    ST_CHK_E = 3'd3,
    ST_DEC   = 3'd4,
    ST_CHK_D = 3'd5,
    ST_PASS  = 3'd6,
    ST_FAIL  = 3'd7
  } kat_state_e;

  localparam int VEC_W     = 320;
  localparam int K1_LSB    = 256;
  localparam int K2_LSB    = 192;
  localparam int K3_LSB    = 128;
  localparam int PT_LSB    = 64;
  localparam int CT_LSB    = 0;
  localparam int KAT_DEPTH = 4;
  localparam int KAT_IDX_W = $clog2(KAT_DEPTH);

  typedef logic [VEC_W-1:0] kat_vec_t;

  // Weak key 0101.. makes single DES an involution, so E(pt)=ct and E(ct)=pt.
  localparam kat_vec_t KAT_TABLE [KAT_DEPTH] = '{
    {64'h0101010101010101, 64'h0101010101010101, 64'h0101010101010101,
     64'h95F8A5E5DD31D900, 64'h8000000000000000},
    {64'h0101010101010101, 64'h0101010101010101, 64'h0101010101010101,
     64'hDD7F121CA5015619, 64'h4000000000000000},
    {64'h0101010101010101, 64'h0101010101010101, 64'h0101010101010101,
     64'h2E8653104F3834EA, 64'h2000000000000000},
    {64'h0101010101010101, 64'h0101010101010101, 64'h0101010101010101,
     64'h4BD388FF6CD81D4F, 64'h1000000000000000}
  };

  // Drop bit 0 of every byte: {k[63:57], k[55:49], ..., k[7:1]}.
  function automatic logic [55:0] strip_parity(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[b*7 +: 7] = k[b*8+1 +: 7];
    end
    return r;
  endfunction

endpackage

// File: rtl/des3_kat_rom.sv
// Combinational idx -> vector lookup into the package table.
// Indices past the table end read as zero.
module des3_kat_rom
  import des3_kat_pkg::*;
(
  input  logic [7:0] idx,
  output kat_vec_t   vec
);

  always_comb begin
    vec = '0;
    if (idx < 8'(KAT_DEPTH)) begin
      vec = KAT_TABLE[idx[KAT_IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/des3_kat_checker.sv
// Known-answer self test for des3: drives each table vector through the core,
// checks the ciphertext, then decrypts it and checks the round trip.
module des3_kat_checker
  import des3_kat_pkg::*;
#(
  parameter int NUM_VEC      = 4,
  parameter int CORE_LATENCY = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_index,
  output logic        fail_phase,
  output logic [63:0] desIn,
  output logic [55:0] key1,
  output logic [55:0] key2,
  output logic [55:0] key3,
  output logic        decrypt,
  input  logic [63:0] desOut,
  output logic [2:0]  dbg_state
);

  localparam int             CNT_W    = $clog2(CORE_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]     LAST_IDX = 8'(NUM_VEC - 1);

  if (NUM_VEC < 1 || NUM_VEC > 256 || NUM_VEC > KAT_DEPTH) begin : g_bad_num_vec
    $error("des3_kat_checker: NUM_VEC out of range");
  end
  if (CORE_LATENCY < 1) begin : g_bad_latency
    $error("des3_kat_checker: CORE_LATENCY must be >= 1");
  end

  kat_state_e       state;
  logic [7:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      exp_pt;
  logic [63:0]      exp_ct;
  kat_vec_t         rom_vec;

  des3_kat_rom u_rom (
    .idx (idx),
    .vec (rom_vec)
  );

  assign dbg_state = state;

  // Handshake: start is a one-cycle pulse honoured only in IDLE (so it is
  // ignored while busy and on the PASS/FAIL edge that raises done); done then
  // holds with pass/fail_* valid until the next accepted start clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_index <= 8'd0;
      fail_phase <= 1'b0;
      desIn      <= 64'd0;
      key1       <= 56'd0;
      key2       <= 56'd0;
      key3       <= 56'd0;
      decrypt    <= 1'b0;
      idx        <= 8'd0;
      cnt        <= CNT_LOAD;
      exp_pt     <= 64'd0;
      exp_ct     <= 64'd0;
    end else begin
      // The wait counter reloads whenever a wait state is entered.
      if (state != ST_ENC && state != ST_DEC) begin
        cnt <= CNT_LOAD;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_index <= 8'd0;
            fail_phase <= 1'b0;
            idx        <= 8'd0;
          end
        end
        ST_LOAD: begin
          key1    <= strip_parity(rom_vec[K1_LSB +: 64]);
          key2    <= strip_parity(rom_vec[K2_LSB +: 64]);
          key3    <= strip_parity(rom_vec[K3_LSB +: 64]);
          desIn   <= rom_vec[PT_LSB +: 64];
          decrypt <= 1'b0;
          exp_pt  <= rom_vec[PT_LSB +: 64];
          exp_ct  <= rom_vec[CT_LSB +: 64];
          state   <= ST_ENC;
        end
        ST_ENC: begin
          if (cnt == CNT_ONE) state <= ST_CHK_E;
          else                cnt   <= cnt - CNT_ONE;
        end
        ST_CHK_E: begin
          if (desOut != exp_ct) begin
            fail_phase <= 1'b0;
            state      <= ST_FAIL;
          end else begin
            desIn   <= desOut;
            decrypt <= 1'b1;
            state   <= ST_DEC;
          end
        end
        ST_DEC: begin
          if (cnt == CNT_ONE) state <= ST_CHK_D;
          else                cnt   <= cnt - CNT_ONE;
        end
        ST_CHK_D: begin
          if (desOut != exp_pt) begin
            fail_phase <= 1'b1;
            state      <= ST_FAIL;
          end else if (idx == LAST_IDX) begin
            state <= ST_PASS;
          end else begin
            idx   <= idx + 8'd1;
            state <= ST_LOAD;
          end
        end
        ST_PASS: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_FAIL: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          pass       <= 1'b0;
          fail_index <= idx;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
